// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: PC owner, req/addr_ok/data_ok fetch FSM, branch redirect latch
//
// Purpose:
//   Fetches one instruction at a time (exactly one request in flight) and
//   presents {ce, pc} plus the instruction to ID, holding them until ID
//   accepts (HOLD and stall[1]==0). Branch targets from ID are latched so a
//   redirect survives ID being bubbled while the delay slot is fetched.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stall[5:0]      pipeline stall bus, stall[1] blocks the ID accept
//   br_bus[32:0]    {br_e, br_addr} from ID
//   inst_req        request valid (REQ state)
//   inst_addr       word-aligned request address
//   inst_addr_ok    address accepted this cycle
//   inst_data_ok    read data valid this cycle
//   inst_rdata      read data
//   if_to_id_bus    {ce, pc}
//   if_inst         instruction for pc, 0 when ce=0
//   stallreq_if     1 while no instruction is ready for ID
//
// Configuration:
//   IF_PERF_CNT_EN  adds perf_wait_cyc / perf_redir saturating counters
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [32:0] if_to_id_bus,
    output logic [31:0] if_inst,
    output logic        stallreq_if
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_wait_cyc,
    output logic [31:0] perf_redir
`endif
);

    localparam logic [1:0] S_REQ  = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    logic        br_e;
    logic [31:0] br_addr;
    logic        accept;
    logic        ce;
    logic [31:0] next_pc;
    logic        unused_stall;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];

    // Only stall[1] matters to IF; the other bits belong to other stages.
    assign unused_stall = ^{stall[5:2], stall[0]};

    assign ce      = (state == S_HOLD);
    assign accept  = ce & ~stall[1];

    // A latched redirect outranks a live br_e: the latch holds the branch
    // that preceded the delay slot now being accepted.
    assign next_pc = redir_v ? redir_pc :
                     br_e    ? br_addr  :
                               out_pc + 32'd4;

    assign inst_req     = (state == S_REQ);
    assign inst_addr    = {fetch_pc[31:2], 2'b00};
    assign if_to_id_bus = {ce, out_pc};
    assign if_inst      = ce ? out_inst : 32'd0;
    assign stallreq_if  = ~ce;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            redir_v  <= 1'b0;
            redir_pc <= 32'd0;
            out_pc   <= 32'd0;
            out_inst <= 32'd0;
        end else begin
            case (state)
                S_REQ: begin
                    if (inst_addr_ok) begin
                        // Response may arrive in the same cycle the address
                        // is accepted; skip WAIT in that case.
                        if (inst_data_ok) begin
                            out_pc   <= fetch_pc;
                            out_inst <= inst_rdata;
                            state    <= S_HOLD;
                        end else begin
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        out_pc   <= fetch_pc;
                        out_inst <= inst_rdata;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        fetch_pc <= next_pc;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            if (accept) begin
                redir_v <= 1'b0;
            end else if (br_e) begin
                redir_v  <= 1'b1;
                redir_pc <= br_addr;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_wait_cyc <= 32'd0;
            perf_redir    <= 32'd0;
        end else begin
            if (stallreq_if && (perf_wait_cyc != 32'hFFFF_FFFF))
                perf_wait_cyc <= perf_wait_cyc + 32'd1;
            if (accept && (redir_v || br_e) && (perf_redir != 32'hFFFF_FFFF))
                perf_redir <= perf_redir + 32'd1;
        end
    end
`endif

endmodule
